mem_ctrl_pipe: RTL and testbench
================================

Name: mem_ctrl_pipe

Overview:
Parametrised single-port word memory with a valid/ready request interface, a configurable registered read pipeline, address range checking and a multi-cycle background wipe.
Successor to the fixed 8x8 memory block: generalised in data width, depth and read latency.
Adds range errors and a synchronous wipe FSM.
Sits between the CPU control unit and its data storage; the flat `mem_block` view is kept for debug/visualisation.

Parameters:
WIDTH, 8, data word width in bits (signed)
DEPTH, 8, number of words
ADDR_W, 4, request address width; must be >= clog2(DEPTH); addresses >= DEPTH are out of range
READ_LATENCY, 1, cycles from read accept to resp_valid; legal range 1..4

Ports:
clk  in  1  single clock, rising edge
clr  in  1  asynchronous, active-high reset; also zeroes the array
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_rw  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  WIDTH  signed write data
resp_valid  out  1  read response strobe, one cycle per accepted read
resp_rdata  out  WIDTH  signed read data; 0 when resp_err
resp_err  out  1  read was out of range; qualified by resp_valid
wr_err  out  1  sticky flag: an out-of-range write was attempted
wipe  in  1  start a background clear of all words
busy  out  1  wipe in progress
mem_block  out  WIDTH*DEPTH  flat array view; word i at bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset (clr high, asynchronous):
  - array, all pipeline stages, resp_valid, resp_rdata, resp_err and wr_err go to 0
  - FSM goes to IDLE
  - req_ready=1 and busy=0 once clr is released
  - clr mid-wipe aborts the wipe; array is still zeroed by clr.
- FSM states: IDLE and SWEEP.
  - req_ready = (state==IDLE) && !wipe. This is combinational; wipe beats a same-cycle request.
- IDLE:
  - wipe=1 -> SWEEP at next edge, sweep pointer=0.
  - Otherwise, if req_valid && req_ready, the request is accepted at that edge.
- Accepted write, in range: mem[addr] <= req_wdata at the accept edge.
- Accepted write, out of range: array unchanged; wr_err <= 1. wr_err stays set until clr or a wipe completes.
- Accepted read:
  - the array is sampled at the accept edge into pipeline stage 1
  - resp_valid is high for exactly one cycle, READ_LATENCY edges after accept
  - READ_LATENCY=1: response is visible in the cycle right after the accept edge.
- Out-of-range read: resp_rdata=0, resp_err=1.
- Back-to-back reads: one accepted per cycle gives one response per cycle, in order. There is no response backpressure.
- A read accepted the cycle after a write to the same address returns the new data. There is one port, so no same-cycle read/write.
- resp_valid=0 cycles: resp_rdata and resp_err hold 0.
- SWEEP:
  - each cycle mem[ptr] <= 0, ptr increments
  - at ptr==DEPTH-1 the state returns to IDLE on that edge and wr_err is cleared
  - the wipe takes exactly DEPTH cycles; busy=1 throughout and req_ready=0
  - the wipe input is ignored during SWEEP.
- Reads accepted before the wipe started still complete in the pipeline, carrying pre-wipe data.
- mem_block reflects the array registers directly, with no extra latency.
- Width rules: ptr and address comparisons use ADDR_W+1 bits to avoid wrap when DEPTH==2**ADDR_W. Data is stored unmodified, with no sign extension inside the block.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state enum {ST_IDLE, ST_SWEEP}
  - constants RW_READ=0 and RW_WRITE=1
  - max READ_LATENCY constant 4.
- One sub-module, mem_rd_pipe: a READ_LATENCY-deep shift register of {valid, err, data} with async clr. The top level holds the array, the FSM and the range check.

Test Plan:
- Assert clr mid-cycle, then release -> all outputs 0, req_ready=1, busy=0, mem_block=0, with no clock edge needed for the outputs to clear.
- Write 0x7F to addr 3, then read addr 3 (READ_LATENCY=1) -> resp_valid one cycle after accept, resp_rdata=0x7F, resp_err=0, mem_block[31:24]=0x7F.
- Read addr 9 with DEPTH=8 -> resp_valid, resp_rdata=0, resp_err=1. Then write -5 to addr 12 -> array unchanged, wr_err=1 and stays 1.
- Fill addrs 0..7 with 1..8, pulse wipe -> busy=1 and req_ready=0 for exactly 8 cycles. Then reads of 0..7 all return 0 and wr_err=0. Also: wipe and req_valid in the same cycle -> request not accepted.
- READ_LATENCY=3, back-to-back reads of addrs 0,1,2 holding 10,20,30 -> three consecutive resp_valid cycles starting 3 edges after the first accept, data 10,20,30 in order.
- Start a wipe at cycle 0 and assert clr at cycle 4 -> FSM IDLE, busy=0, whole array 0, no resp_valid after clr is released.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the pipelined word memory controller.
//   state_t          : wipe FSM state encoding (IDLE / SWEEP)
//   RW_READ/RW_WRITE : encoding of the req_rw request field
//   MAX_READ_LATENCY : deepest read pipeline the controller supports
package mem_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response pipeline: LATENCY-deep shift register of {valid, err, data}.
// Stage 0 is loaded at the read-accept edge, so the output (last stage) is
// visible LATENCY edges after the accept.
//   clk      : clock, rising edge
//   clr      : asynchronous active-high clear of every stage
//   in_valid : a read was accepted this cycle
//   in_err   : that read was out of range
//   in_data  : sampled word (already 0 for errors and idle cycles)
//   out_*    : last-stage view, drives the response port directly
module mem_rd_pipe #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in_err,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic             out_err,
   output logic [WIDTH-1:0] out_data
);

   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         logic             valid_reg;
         logic             err_reg;
         logic [WIDTH-1:0] data_reg;
         logic             valid_next;
         logic             err_next;
         logic [WIDTH-1:0] data_next;

         if (gi == 0) begin : g_head
            assign valid_next = in_valid;
            assign err_next   = in_err;
            assign data_next  = in_data;
         end else begin : g_body
            assign valid_next = g_stage[gi-1].valid_reg;
            assign err_next   = g_stage[gi-1].err_reg;
            assign data_next  = g_stage[gi-1].data_reg;
         end

         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               valid_reg <= 1'b0;
               err_reg   <= 1'b0;
               data_reg  <= '0;
            end else begin
               valid_reg <= valid_next;
               err_reg   <= err_next;
               data_reg  <= data_next;
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[LATENCY-1].valid_reg;
   assign out_err   = g_stage[LATENCY-1].err_reg;
   assign out_data  = g_stage[LATENCY-1].data_reg;

endmodule

// File: rtl/mem_ctrl_pipe.sv
// Single-port word memory with valid/ready requests, a registered read
// pipeline, address range checking and a DEPTH-cycle background wipe.
//   clk        : clock, rising edge
//   clr        : asynchronous active-high reset, also zeroes the array
//   req_valid/req_ready/req_rw/req_addr/req_wdata : request channel
//   resp_valid/resp_rdata/resp_err : read response, no backpressure
//   wr_err     : sticky out-of-range write flag (cleared by clr or wipe end)
//   wipe/busy  : start / progress of the background clear
//   mem_block  : flat view of the array, word i at [i*WIDTH +: WIDTH]
// READ_LATENCY must lie in 1..MAX_READ_LATENCY; DEPTH must be >= 1.
module mem_ctrl_pipe
   import mem_ctrl_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 8,
   parameter int ADDR_W       = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_rw,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [WIDTH-1:0]        req_wdata,
   output logic                    resp_valid,
   output logic [WIDTH-1:0]        resp_rdata,
   output logic                    resp_err,
   output logic                    wr_err,
   input  logic                    wipe,
   output logic                    busy,
   output logic [WIDTH*DEPTH-1:0]  mem_block
);

   // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   state_t           state_reg;
   logic [ADDR_W:0]  ptr_reg;
   logic             wr_err_reg;

   logic [ADDR_W:0]  addr_ext;
   logic             in_range;
   logic             accept;
   logic             wr_acc;
   logic             rd_acc;
   logic             sweeping;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] rd_data_in;
   logic             rd_err_in;

   assign sweeping  = (state_reg == ST_SWEEP);
   assign req_ready = (state_reg == ST_IDLE) && !wipe;
   assign busy      = sweeping;
   assign wr_err    = wr_err_reg;

   assign addr_ext = {1'b0, req_addr};
   assign in_range = (addr_ext < DEPTH_C);
   assign accept   = req_valid && req_ready;
   assign wr_acc   = accept && (req_rw == RW_WRITE);
   assign rd_acc   = accept && (req_rw == RW_READ);

   // Array: sweep and request writes are exclusive because req_ready is low
   // whenever the FSM is sweeping.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (sweeping && (ptr_reg == (ADDR_W+1)'(i))) begin
               mem_reg[i] <= '0;
            end else if (wr_acc && (addr_ext == (ADDR_W+1)'(i))) begin
               mem_reg[i] <= req_wdata;
            end
         end
      end
   end

   // Wipe FSM and sticky write-error flag.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg  <= ST_IDLE;
         ptr_reg    <= '0;
         wr_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (wipe) begin
                  state_reg <= ST_SWEEP;
                  ptr_reg   <= '0;
               end else if (wr_acc && !in_range) begin
                  wr_err_reg <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (ptr_reg == LAST_C) begin
                  state_reg  <= ST_IDLE;
                  ptr_reg    <= '0;
                  wr_err_reg <= 1'b0;
               end else begin
                  ptr_reg <= ptr_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               ptr_reg   <= '0;
            end
         endcase
      end
   end

   // Read mux; out-of-range addresses match no word and yield 0.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_ext == (ADDR_W+1)'(i)) begin
            rd_word = mem_reg[i];
         end
      end
   end

   // Zero data on idle and error cycles so the response port idles at 0.
   assign rd_data_in = (rd_acc && in_range) ? rd_word : '0;
   assign rd_err_in  = rd_acc && !in_range;

   mem_rd_pipe #(
      .WIDTH   (WIDTH),
      .LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (rd_acc),
      .in_err    (rd_err_in),
      .in_data   (rd_data_in),
      .out_valid (resp_valid),
      .out_err   (resp_err),
      .out_data  (resp_rdata)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_view
         assign mem_block[gi*WIDTH +: WIDTH] = mem_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_mem_ctrl_pipe.sv
module tb_mem_ctrl_pipe;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic req_valid = 1'b0;
   logic req_rw = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [WIDTH-1:0] req_wdata = '0;
   logic wipe = 1'b0;

   logic a_ready, a_rvalid, a_rerr, a_werr, a_busy;
   logic [WIDTH-1:0] a_rdata;
   logic [WIDTH*DEPTH-1:0] a_mem;
   logic b_ready, b_rvalid, b_rerr, b_werr, b_busy;
   logic [WIDTH-1:0] b_rdata;
   logic [WIDTH*DEPTH-1:0] b_mem;

   always #5 clk = ~clk;

   mem_ctrl_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(1)) dut_l1 (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(a_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(a_rvalid), .resp_rdata(a_rdata),
      .resp_err(a_rerr), .wr_err(a_werr), .wipe(wipe), .busy(a_busy), .mem_block(a_mem));

   mem_ctrl_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(3)) dut_l3 (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(b_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_rvalid), .resp_rdata(b_rdata),
      .resp_err(b_rerr), .wr_err(b_werr), .wipe(wipe), .busy(b_busy), .mem_block(b_mem));

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             err;
      int               cyc;
   } exp_t;

   exp_t q_l1[$];
   exp_t q_l3[$];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [WIDTH-1:0] model_mem [DEPTH];
   logic             model_werr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_block();
      logic [63:0] r;
      for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = model_mem[i];
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitors: one line per observed response.
   always @(negedge clk) begin
      if (!clr) begin
         if (a_rvalid) begin
            if (q_l1.size() == 0) begin
               check("l1_unexpected_resp", 1, 0);
            end else begin
               exp_t e;
               e = q_l1.pop_front();
               $display("[TB] L1 resp cyc=%0d data=0x%0h err=%0b", cyc, a_rdata, a_rerr);
               check("l1_data", a_rdata, e.data);
               check("l1_err", a_rerr, e.err);
               check("l1_cycle", cyc, e.cyc);
            end
         end else begin
            check("l1_idle_zero", {a_rerr, a_rdata}, 0);
         end
         if (b_rvalid) begin
            if (q_l3.size() == 0) begin
               check("l3_unexpected_resp", 1, 0);
            end else begin
               exp_t e;
               e = q_l3.pop_front();
               $display("[TB] L3 resp cyc=%0d data=0x%0h err=%0b", cyc, b_rdata, b_rerr);
               check("l3_data", b_rdata, e.data);
               check("l3_err", b_rerr, e.err);
               check("l3_cycle", cyc, e.cyc);
            end
         end else begin
            check("l3_idle_zero", {b_rerr, b_rdata}, 0);
         end
      end
   end

   // Drive one request; it is accepted at the next rising edge.
   task automatic do_req(input logic rw, input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wd);
      exp_t e;
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_wdata = wd;
      #1;
      check("ready_l1", a_ready, 1);
      check("ready_l3", b_ready, 1);
      if (rw == 1'b0) begin
         e.err  = (addr >= DEPTH);
         e.data = e.err ? '0 : model_mem[addr];
         e.cyc  = cyc + 1;
         q_l1.push_back(e);
         e.cyc  = cyc + 3;
         q_l3.push_back(e);
         $display("[TB] read  addr=%0d exp=0x%0h err=%0b", addr, e.data, e.err);
      end else begin
         if (addr < DEPTH) model_mem[addr] = wd;
         else model_werr = 1'b1;
         $display("[TB] write addr=%0d data=0x%0h", addr, wd);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_mem_l1"}, a_mem, model_block());
      check({tag, "_mem_l3"}, b_mem, model_block());
      check({tag, "_werr_l1"}, a_werr, model_werr);
      check({tag, "_werr_l3"}, b_werr, model_werr);
   endtask

   task automatic do_wipe_count(input string tag);
      int busy_cnt;
      int rdy_bad;
      busy_cnt = 0;
      rdy_bad = 0;
      wipe = 1'b1;
      @(posedge clk);
      #1;
      wipe = 1'b0;
      req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (a_busy) busy_cnt++;
         if (a_busy && (a_ready || b_ready)) rdy_bad++;
         if (!a_busy) break;
      end
      check({tag, "_busy_cycles"}, busy_cnt, DEPTH);
      check({tag, "_ready_low"}, rdy_bad, 0);
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_werr = 1'b0;
      #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_werr = 1'b0;

      // Asynchronous reset between edges: outputs clear without a clock edge.
      #2 clr = 1'b1;
      #2;
      check("rst_resp", {a_rvalid, a_rerr, a_rdata, b_rvalid, b_rerr, b_rdata}, 0);
      check("rst_busy", {a_busy, b_busy}, 0);
      check_state("rst");
      idle(2);
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("rst_ready", {a_ready, b_ready}, 2'b11);
      idle(1);

      // Write then read back.
      do_req(1'b1, 4'd3, 8'h7F);
      check("w3_block", a_mem[31:24], 8'h7F);
      do_req(1'b0, 4'd3, 8'h00);
      idle(4);

      // Out-of-range read and write.
      do_req(1'b0, 4'd9, 8'h00);
      do_req(1'b1, 4'd12, 8'hFB);
      check_state("oor");
      idle(5);
      check_state("oor_sticky");

      // Fill, then read the first word just before a wipe that collides with a request.
      for (int i = 0; i < DEPTH; i++) do_req(1'b1, 4'(i), 8'(i + 1));
      check_state("fill");
      do_req(1'b0, 4'd0, 8'h00);
      req_valid = 1'b1;
      req_rw    = 1'b1;
      req_addr  = 4'd1;
      req_wdata = 8'h99;
      wipe      = 1'b1;
      #1;
      check("wipe_beats_req", {a_ready, b_ready}, 0);
      do_wipe_count("wipe");
      check_state("wiped");
      for (int i = 0; i < DEPTH; i++) do_req(1'b0, 4'(i), 8'h00);
      idle(5);

      // Back-to-back reads (checked for ordering/timing in both latencies).
      do_req(1'b1, 4'd0, 8'd10);
      do_req(1'b1, 4'd1, 8'd20);
      do_req(1'b1, 4'd2, 8'd30);
      do_req(1'b0, 4'd0, 8'h00);
      do_req(1'b0, 4'd1, 8'h00);
      do_req(1'b0, 4'd2, 8'h00);
      do_req(1'b0, 4'd15, 8'h00);
      do_req(1'b1, 4'd7, 8'h80);
      do_req(1'b0, 4'd7, 8'h00);
      idle(6);
      check_state("b2b");

      // Wipe aborted by clr four cycles in.
      wipe = 1'b1;
      @(posedge clk);
      #1;
      wipe = 1'b0;
      idle(3);
      check("abort_busy_before", a_busy, 1);
      #2 clr = 1'b1;
      #1;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_werr = 1'b0;
      check("abort_busy", {a_busy, b_busy}, 0);
      check_state("abort");
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("abort_ready", {a_ready, b_ready}, 2'b11);
      idle(6);
      check("abort_busy_after", {a_busy, b_busy}, 0);

      check("q_l1_empty", q_l1.size(), 0);
      check("q_l3_empty", q_l3.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
